isr_serial_buf: RTL
===================

Name: isr_serial_buf

Overview:
- Byte-serial inverse ShiftRows unit with a double buffer, for the decryption datapath.
- Accepts an AES state one byte per cycle in state byte order (byte k = state bits [8k+:8], k = 4*col + row).
- Emits the same 16 bytes in InvShiftRows order.
- Two 16-byte banks in ping-pong: one block fills while the previous block drains, sustaining 1 byte/cycle.

Parameters:
- D, 1, number of shares per byte. Each lane is 8*D bits, share s at [8s+:8]. The same permutation applies to all shares; shares are never combined.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  unit can accept an input byte
- in_data  input  8*D  input byte lane (all shares)
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accepts the output byte
- out_data  output  8*D  output byte lane
- out_last  output  1  high with output byte index 15 of a block

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Storage: 2 banks x 16 lanes of 8*D bits, plus a full flag per bank.
- Pointers and counters:
  - wr_bank (1b) and wr_cnt (4b): the input byte at wr_cnt is written to bank[wr_bank][wr_cnt].
  - rd_bank (1b) and rd_cnt (4b).
- Write side:
  - in_ready = !full[wr_bank].
  - When wr_cnt wraps from 15 to 0: set full[wr_bank] and toggle wr_bank.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][src(rd_cnt)], where for k = 4j+i: src(k) = 4*((j - i) mod 4) + i.
  - Resulting source order: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
  - out_last = out_valid && rd_cnt == 15.
  - When rd_cnt wraps from 15 to 0: clear full[rd_bank] and toggle rd_bank.
- Latency: store-and-forward. out_valid rises the cycle after the 16th input byte of a block is accepted, provided the read side is idle.
- Throughput: 1 byte/cycle sustained when in_valid and out_ready are held high.
- Both banks full: in_ready = 0; in_data is ignored.
- Both banks empty: out_valid = 0.
- Simultaneous events in one cycle:
  - A set of full on one bank and a clear on the other both take effect.
  - A write to a bank and a read from the other bank are independent.
  - A given bank is never written and read in the same cycle, since write requires !full and read requires full.
- Reset (async assert, sync deassert, applies mid-block too):
  - All pointers and counters go to 0 and full flags to 0, which gives in_ready = 1, out_valid = 0 and out_last = 0.
  - Partially received or partially drained blocks are discarded.
- Bank contents are not reset.
- out_data is don't-care while out_valid = 0; the bench must not check it then.
- No combinational path from in_valid to out_valid.
- No combinational path from out_ready to in_ready.

Optional Feature:
- ISR_FWD_MODE_EN defined:
  - Adds input port fwd (1b), sampled with the first byte of each block (wr_cnt == 0) and stored per bank.
  - Bank flag 1 selects forward ShiftRows order, src(k) = 4*((j + i) mod 4) + i, for that block's drain.
  - Bank flag 0 selects inverse order.
  - The flag resets to 0.
- Not defined: no fwd port; inverse order only.

Decomposition:
- Shared package aes_sr_pkg:
  - AES_NBYTES = 16.
  - Byte-lane typedef parameterised by D.
  - Functions isr_src_idx(k) and sr_src_idx(k), each returning a 4b source index.
  - The same package serves the existing combinational ShiftRows.
- One natural sub-module, sr_bank_rf: a 16-entry register file with 1 write port, 1 read port and an async read mux. It is instantiated twice, or as one 2-bank instance.
- Pointer and flag control lives in the top module.

Test Plan:
- Single block, D=1, in_data 0x00..0x0F, out_ready = 1 → out_data sequence 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. out_last only on 03. out_valid rises 1 cycle after in byte 0x0F is accepted.
- Back-to-back blocks: 3 blocks streamed with in_valid = 1 and out_ready = 1 → 48 output bytes in the correct per-block order. After the first block's fill, there are no gaps on either side.
- Backpressure: out_ready = 0 while 2 blocks are written → in_ready drops after byte 31 is accepted. Raising out_ready → in_ready returns 1 the cycle after block 0 byte 15 drains. out_data is stable during stalls.
- D=2 share independence: share0 = 0x00..0x0F, share1 = 0xF0..0xFF → each share is permuted identically, e.g. output byte 1 = {0xFD, 0x0D}.
- Reset mid-operation: assert rst_n = 0 after 9 input bytes while a prior block is at rd_cnt = 5 → out_valid = 0 and in_ready = 1 immediately. A fresh block afterwards yields the correct order, with no stale bytes.
- With ISR_FWD_MODE_EN: fwd = 1 on input 0x00..0x0F → output 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B. The next block with fwd = 0 → inverse order.

Source files
------------

// File: rtl/aes_sr_pkg.sv
// Shared AES ShiftRows helpers: the byte count and the source-index maps for the
// forward and inverse row rotations, used by both the serial and combinational units.
package aes_sr_pkg;

    localparam int AES_NBYTES = 16;

    typedef logic [3:0] aes_idx_t;
    typedef logic [7:0] aes_share_t;

    // State byte k = 4*col + row; inverse rotation pulls from column (col - row) mod 4.
    function automatic aes_idx_t isr_src_idx(input aes_idx_t k);
        logic [1:0] col;
        logic [1:0] row;
        logic [1:0] src_col;
        col     = k[3:2];
        row     = k[1:0];
        src_col = col - row;
        return {src_col, row};
    endfunction

    function automatic aes_idx_t sr_src_idx(input aes_idx_t k);
        logic [1:0] col;
        logic [1:0] row;
        logic [1:0] src_col;
        col     = k[3:2];
        row     = k[1:0];
        src_col = col + row;
        return {src_col, row};
    endfunction

endpackage

// File: rtl/sr_bank_rf.sv
// 16-entry lane register file: one synchronous write port, one asynchronous read port.
module sr_bank_rf
    import aes_sr_pkg::*;
#(
    parameter int D = 1
) (
    input  logic             clk,
    input  logic             we,
    input  aes_idx_t         waddr,
    input  logic [8*D-1:0]   wdata,
    input  aes_idx_t         raddr,
    output logic [8*D-1:0]   rdata
);

    typedef logic [8*D-1:0] lane_t;

    // Contents are deliberately left unreset; the full flags gate every read.
    lane_t mem_q [AES_NBYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/isr_serial_buf.sv
// Byte-serial InvShiftRows with a ping-pong pair of 16-byte banks (1 byte/cycle sustained).
// Define ISR_FWD_MODE_EN to add a per-block fwd input selecting forward ShiftRows order.
module isr_serial_buf
    import aes_sr_pkg::*;
#(
    parameter int D = 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ISR_FWD_MODE_EN
    input  logic             fwd,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*D-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*D-1:0]   out_data,
    output logic             out_last
);

    typedef logic [8*D-1:0] lane_t;

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    aes_idx_t   wr_cnt_q, wr_cnt_d;
    aes_idx_t   rd_cnt_q, rd_cnt_d;
    logic [1:0] full_q, full_d;

    logic       in_fire;
    logic       out_fire;
    aes_idx_t   rd_src;
    lane_t      rd_lane0;
    lane_t      rd_lane1;

    // Handshake outputs depend only on flops, never on the opposite side's inputs.
    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && (rd_cnt_q == 4'd15);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Set and clear always target different banks, so both may land in one cycle.
        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

`ifdef ISR_FWD_MODE_EN
    logic [1:0] fwd_q, fwd_d;

    // The order flag travels with its block: captured on byte 0, applied on drain.
    always_comb begin
        fwd_d = fwd_q;
        if (in_fire && (wr_cnt_q == 4'd0)) begin
            fwd_d[wr_bank_q] = fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end

    assign rd_src = fwd_q[rd_bank_q] ? sr_src_idx(rd_cnt_q) : isr_src_idx(rd_cnt_q);
`else
    assign rd_src = isr_src_idx(rd_cnt_q);
`endif

    sr_bank_rf #(.D(D)) u_bank0 (
        .clk   (clk),
        .we    (in_fire && !wr_bank_q),
        .waddr (wr_cnt_q),
        .wdata (in_data),
        .raddr (rd_src),
        .rdata (rd_lane0)
    );

    sr_bank_rf #(.D(D)) u_bank1 (
        .clk   (clk),
        .we    (in_fire && wr_bank_q),
        .waddr (wr_cnt_q),
        .wdata (in_data),
        .raddr (rd_src),
        .rdata (rd_lane1)
    );

    assign out_data = rd_bank_q ? rd_lane1 : rd_lane0;

endmodule
